mips150_echo: RTL and testbench

- Serial echo top-level for the MIPS150 board image.
- Receives 8N1 UART bytes on FPGA_SERIAL_RX and retransmits each byte unchanged on FPGA_SERIAL_TX, implementing the system-level echo behaviour of the MIPS150 CPU running its echo loop.
- Contains a UART receiver, a 2-entry byte FIFO and a UART transmitter.
- Connects directly to the board serial pins, or to a host-side UART model in simulation.

---
 rtl/mips150_echo.sv | 232 +++++++++++++++++++++++
 tb/tb_mips150_echo.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips150_echo.sv
// rtl/mips150_echo.sv - UART echo: 8N1 receiver, 2-entry byte FIFO, 8N1 transmitter
module mips150_echo #(
   parameter int ClockFreq = 50_000_000,
   parameter int BaudRate  = 115_200
) (
   input  logic clk,
   input  logic rst,
   input  logic FPGA_SERIAL_RX,
   output logic FPGA_SERIAL_TX
);
   localparam int          BitCycles = ClockFreq / BaudRate;
   localparam logic [15:0] BitLast   = 16'(BitCycles - 1);
   localparam logic [15:0] HalfLast  = 16'(BitCycles / 2 - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

   // Receive path: two-flop synchronizer plus one delayed copy for falling-edge detection
   logic rx_s1_q, rx_s2_q, rx_prev_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_s1_q   <= 1'b1;
         rx_s2_q   <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_s1_q   <= FPGA_SERIAL_RX;
         rx_s2_q   <= rx_s1_q;
         rx_prev_q <= rx_s2_q;
      end
   end

   uart_state_e rx_state_q, rx_state_d;
   logic [15:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]  rx_bit_q, rx_bit_d;
   logic [7:0]  rx_shift_q, rx_shift_d;
   logic        rx_push;

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_push    = 1'b0;
      case (rx_state_q)
         S_IDLE: begin
            // Needs a high-to-low transition, so a line held low after a framing error cannot re-arm
            if (rx_prev_q && !rx_s2_q) begin
               rx_state_d = S_START;
               rx_cnt_d   = 16'd0;
            end
         end
         S_START: begin
            if (rx_cnt_q == HalfLast) begin
               rx_cnt_d   = 16'd0;
               rx_bit_d   = 3'd0;
               rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
            end else begin
               rx_cnt_d = rx_cnt_q + 16'd1;
            end
         end
         S_DATA: begin
            if (rx_cnt_q == BitLast) begin
               rx_cnt_d   = 16'd0;
               rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
               if (rx_bit_q == 3'd7) begin
                  rx_state_d = S_STOP;
               end else begin
                  rx_bit_d = rx_bit_q + 3'd1;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + 16'd1;
            end
         end
         S_STOP: begin
            if (rx_cnt_q == BitLast) begin
               rx_cnt_d   = 16'd0;
               rx_push    = rx_s2_q;
               rx_state_d = S_IDLE;
            end else begin
               rx_cnt_d = rx_cnt_q + 16'd1;
            end
         end
         default: rx_state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_state_q <= S_IDLE;
         rx_cnt_q   <= 16'd0;
         rx_bit_q   <= 3'd0;
         rx_shift_q <= 8'd0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
      end
   end

   // Two-entry FIFO; a push while full is accepted only if the same cycle pops
   logic [7:0] fifo_mem_q [2];
   logic [7:0] fifo_mem_d [2];
   logic       fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
   logic [1:0] fifo_cnt_q, fifo_cnt_d;
   logic       fifo_empty, fifo_full, tx_pop, push_ok, pop_ok;

   assign fifo_empty = (fifo_cnt_q == 2'd0);
   assign fifo_full  = (fifo_cnt_q == 2'd2);

   always_comb begin
      fifo_mem_d = fifo_mem_q;
      fifo_wr_d  = fifo_wr_q;
      fifo_rd_d  = fifo_rd_q;
      fifo_cnt_d = fifo_cnt_q;
      pop_ok     = tx_pop && !fifo_empty;
      push_ok    = rx_push && (!fifo_full || pop_ok);
      if (push_ok) begin
         fifo_mem_d[fifo_wr_q] = rx_shift_q;
         fifo_wr_d             = ~fifo_wr_q;
      end
      if (pop_ok) begin
         fifo_rd_d = ~fifo_rd_q;
      end
      if (push_ok && !pop_ok) begin
         fifo_cnt_d = fifo_cnt_q + 2'd1;
      end else if (pop_ok && !push_ok) begin
         fifo_cnt_d = fifo_cnt_q - 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fifo_mem_q[0] <= 8'd0;
         fifo_mem_q[1] <= 8'd0;
         fifo_wr_q     <= 1'b0;
         fifo_rd_q     <= 1'b0;
         fifo_cnt_q    <= 2'd0;
      end else begin
         fifo_mem_q <= fifo_mem_d;
         fifo_wr_q  <= fifo_wr_d;
         fifo_rd_q  <= fifo_rd_d;
         fifo_cnt_q <= fifo_cnt_d;
      end
   end

   uart_state_e tx_state_q, tx_state_d;
   logic [15:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]  tx_bit_q, tx_bit_d;
   logic [7:0]  tx_shift_q, tx_shift_d;
   logic        tx_q, tx_d;

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_pop     = 1'b0;
      case (tx_state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               tx_pop     = 1'b1;
               tx_shift_d = fifo_mem_q[fifo_rd_q];
               tx_cnt_d   = 16'd0;
               tx_state_d = S_START;
            end
         end
         S_START: begin
            if (tx_cnt_q == BitLast) begin
               tx_cnt_d   = 16'd0;
               tx_bit_d   = 3'd0;
               tx_state_d = S_DATA;
            end else begin
               tx_cnt_d = tx_cnt_q + 16'd1;
            end
         end
         S_DATA: begin
            if (tx_cnt_q == BitLast) begin
               tx_cnt_d = 16'd0;
               if (tx_bit_q == 3'd7) begin
                  tx_state_d = S_STOP;
               end else begin
                  tx_bit_d   = tx_bit_q + 3'd1;
                  tx_shift_d = {1'b0, tx_shift_q[7:1]};
               end
            end else begin
               tx_cnt_d = tx_cnt_q + 16'd1;
            end
         end
         S_STOP: begin
            // Chaining straight into the next start bit keeps back-to-back frames gapless
            if (tx_cnt_q == BitLast) begin
               tx_cnt_d = 16'd0;
               if (!fifo_empty) begin
                  tx_pop     = 1'b1;
                  tx_shift_d = fifo_mem_q[fifo_rd_q];
                  tx_state_d = S_START;
               end else begin
                  tx_state_d = S_IDLE;
               end
            end else begin
               tx_cnt_d = tx_cnt_q + 16'd1;
            end
         end
         default: tx_state_d = S_IDLE;
      endcase
      case (tx_state_d)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = tx_shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_state_q <= S_IDLE;
         tx_cnt_q   <= 16'd0;
         tx_bit_q   <= 3'd0;
         tx_shift_q <= 8'd0;
         tx_q       <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         tx_q       <= tx_d;
      end
   end

   assign FPGA_SERIAL_TX = tx_q;

endmodule

// File: tb/tb_mips150_echo.sv
// tb/tb_mips150_echo.sv - self-checking bench for the serial echo top with a host UART model
`timescale 1ns/1ps
module tb_mips150_echo;
   localparam int BC      = 50_000_000 / 115_200;
   localparam int FRAME   = 10 * BC;
   localparam int STOPMID = 9 * BC + BC / 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic rx  = 1'b1;
   logic tx;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;

   logic [7:0] got_q [$];
   int         got_t [$];
   logic [7:0] exp_q [$];
   int         edge_cnt   = 0;
   int         mon_ferr   = 0;
   int         mon_glitch = 0;
   logic       mon_busy   = 1'b0;
   int         mon_cnt    = 0;
   int         mon_t0     = 0;
   logic [7:0] mon_byte   = 8'd0;
   logic       tx_last    = 1'b1;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mips150_echo dut (
      .clk            (clk),
      .rst            (rst),
      .FPGA_SERIAL_RX (rx),
      .FPGA_SERIAL_TX (tx)
   );

   // Host-side receiver: samples each bit at its midpoint, sampling on the falling clock edge
   initial begin
      forever begin
         @(negedge clk);
         if (tx !== tx_last) edge_cnt++;
         tx_last = tx;
         if (!rst) begin
            mon_busy = 1'b0;
         end else if (!mon_busy) begin
            if (tx === 1'b0) begin
               mon_busy = 1'b1;
               mon_cnt  = 0;
               mon_t0   = cyc;
            end
         end else begin
            mon_cnt++;
            if (mon_cnt == BC / 2 && tx !== 1'b0) begin
               mon_glitch++;
               mon_busy = 1'b0;
            end
            for (int k = 1; k <= 8; k++)
               if (mon_cnt == k * BC + BC / 2) mon_byte[k-1] = tx;
            if (mon_cnt == STOPMID) begin
               if (tx !== 1'b1) mon_ferr++;
               else begin
                  got_q.push_back(mon_byte);
                  got_t.push_back(mon_t0);
               end
               mon_busy = 1'b0;
            end
         end
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop, output int t0);
      logic [9:0] f;
      f  = {stop, b, 1'b0};
      t0 = cyc;
      for (int i = 0; i < 10; i++) begin
         rx = f[i];
         wait_cyc(BC);
      end
      rx = 1'b1;
   endtask

   task automatic wait_echo(input int n);
      int budget;
      budget = (n + 1) * FRAME + 2000;
      while (budget > 0 && got_q.size() < n) begin
         @(posedge clk);
         budget--;
      end
      wait_cyc(1000);
   endtask

   task automatic clear_queues;
      got_q.delete();
      got_t.delete();
      exp_q.delete();
   endtask

   task automatic test_reset;
      int e0;
      rst = 1'b0;
      rx  = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      n_vec++;
      if (tx !== 1'b1) begin n_err++; $display("FAIL reset_tx: got %b expected 1", tx); end
      rst = 1'b1;
      e0  = edge_cnt;
      wait_cyc(1000);
      n_vec++;
      if (edge_cnt - e0 != 0) begin n_err++; $display("FAIL idle_edges: got %0d expected 0", edge_cnt - e0); end
      n_vec++;
      if (tx !== 1'b1) begin n_err++; $display("FAIL idle_tx: got %b expected 1", tx); end
      n_vec++;
      if (got_q.size() != 0) begin n_err++; $display("FAIL idle_bytes: got %0d expected 0", got_q.size()); end
   endtask

   task automatic test_single;
      int t0, lat, f0;
      clear_queues();
      f0 = mon_ferr + mon_glitch;
      exp_q.push_back(8'h7A);
      send_frame(8'h7A, 1'b1, t0);
      wait_echo(1);
      n_vec++;
      if (got_q.size() != 1) begin n_err++; $display("FAIL single_count: got %0d expected 1", got_q.size()); end
      if (got_q.size() >= 1) begin
         n_vec++;
         if (got_q[0] !== exp_q[0]) begin n_err++; $display("FAIL single_data: got %02h expected %02h", got_q[0], exp_q[0]); end
         lat = got_t[0] - t0 - STOPMID;
         n_vec++;
         if (lat < 0 || lat > 6) begin n_err++; $display("FAIL single_latency: got %0d expected 0..6 clocks", lat); end
      end
      n_vec++;
      if (mon_ferr + mon_glitch != f0) begin n_err++; $display("FAIL single_frame_err: got %0d expected %0d", mon_ferr + mon_glitch, f0); end
   endtask

   task automatic test_back_to_back;
      int t0, f0;
      logic [7:0] pat [3];
      pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'h55;
      clear_queues();
      f0 = mon_ferr + mon_glitch;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(pat[i]);
         send_frame(pat[i], 1'b1, t0);
      end
      wait_echo(3);
      n_vec++;
      if (got_q.size() != 3) begin n_err++; $display("FAIL b2b_count: got %0d expected 3", got_q.size()); end
      for (int i = 0; i < 3 && i < got_q.size(); i++) begin
         n_vec++;
         if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL b2b_data%0d: got %02h expected %02h", i, got_q[i], exp_q[i]); end
      end
      for (int i = 1; i < got_t.size(); i++) begin
         n_vec++;
         if (got_t[i] - got_t[i-1] != FRAME) begin n_err++; $display("FAIL b2b_spacing%0d: got %0d expected %0d", i, got_t[i] - got_t[i-1], FRAME); end
      end
      n_vec++;
      if (mon_ferr + mon_glitch != f0) begin n_err++; $display("FAIL b2b_frame_err: got %0d expected %0d", mon_ferr + mon_glitch, f0); end
   endtask

   task automatic test_framing;
      int t0;
      clear_queues();
      send_frame(8'h3C, 1'b0, t0);
      wait_cyc(2 * BC);
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1, t0);
      wait_echo(1);
      n_vec++;
      if (got_q.size() != 1) begin n_err++; $display("FAIL framing_count: got %0d expected 1", got_q.size()); end
      if (got_q.size() >= 1) begin
         n_vec++;
         if (got_q[0] !== exp_q[0]) begin n_err++; $display("FAIL framing_data: got %02h expected %02h", got_q[0], exp_q[0]); end
      end
   endtask

   task automatic test_glitch;
      int e0;
      clear_queues();
      e0 = edge_cnt;
      rx = 1'b0;
      wait_cyc(100);
      rx = 1'b1;
      wait_cyc(3000);
      n_vec++;
      if (edge_cnt - e0 != 0) begin n_err++; $display("FAIL glitch_edges: got %0d expected 0", edge_cnt - e0); end
      n_vec++;
      if (got_q.size() != 0) begin n_err++; $display("FAIL glitch_bytes: got %0d expected 0", got_q.size()); end
      n_vec++;
      if (tx !== 1'b1) begin n_err++; $display("FAIL glitch_tx: got %b expected 1", tx); end
   endtask

   task automatic test_reset_mid;
      int t0;
      logic [9:0] f;
      clear_queues();
      send_frame(8'h7A, 1'b1, t0);
      f = {1'b1, 8'h55, 1'b0};
      for (int i = 0; i < 4; i++) begin
         rx = f[i];
         wait_cyc(BC);
      end
      n_vec++;
      if (mon_busy !== 1'b1) begin n_err++; $display("FAIL rstmid_in_frame: got %b expected 1", mon_busy); end
      #3;
      rst = 1'b0;
      #1;
      n_vec++;
      if (tx !== 1'b1) begin n_err++; $display("FAIL rstmid_async_tx: got %b expected 1", tx); end
      rx = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      rst = 1'b1;
      n_vec++;
      if (got_q.size() != 0) begin n_err++; $display("FAIL rstmid_partial: got %0d expected 0", got_q.size()); end
      wait_cyc(2 * BC);
      exp_q.push_back(8'h12);
      send_frame(8'h12, 1'b1, t0);
      wait_echo(1);
      n_vec++;
      if (got_q.size() != 1) begin n_err++; $display("FAIL rstmid_count: got %0d expected 1", got_q.size()); end
      if (got_q.size() >= 1) begin
         n_vec++;
         if (got_q[0] !== exp_q[0]) begin n_err++; $display("FAIL rstmid_data: got %02h expected %02h", got_q[0], exp_q[0]); end
      end
   endtask

   task automatic test_random;
      int t0, gap, f0;
      logic [7:0] b;
      clear_queues();
      f0 = mon_ferr + mon_glitch;
      for (int i = 0; i < 3; i++) begin
         b   = 8'($urandom_range(0, 255));
         gap = int'($urandom_range(0, 200));
         exp_q.push_back(b);
         send_frame(b, 1'b1, t0);
         if (gap > 0) wait_cyc(gap);
      end
      wait_echo(3);
      n_vec++;
      if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_vec++;
         if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand_data%0d: got %02h expected %02h", i, got_q[i], exp_q[i]); end
      end
      n_vec++;
      if (mon_ferr + mon_glitch != f0) begin n_err++; $display("FAIL rand_frame_err: got %0d expected %0d", mon_ferr + mon_glitch, f0); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_framing();
      test_glitch();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
